// File: rtl/fft32_input_buffer.sv
// Ping-pong serial-to-parallel frame buffer: fills one 32-sample bank while the
// other is presented in parallel to the first FFT butterfly stage.
module fft32_input_buffer #(
  parameter int DW = 8,
  parameter int N  = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_data,
  input  logic                 in_sof,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] x0_r,
  output logic signed [DW-1:0] x1_r,
  output logic signed [DW-1:0] x2_r,
  output logic signed [DW-1:0] x3_r,
  output logic signed [DW-1:0] x4_r,
  output logic signed [DW-1:0] x5_r,
  output logic signed [DW-1:0] x6_r,
  output logic signed [DW-1:0] x7_r,
  output logic signed [DW-1:0] x8_r,
  output logic signed [DW-1:0] x9_r,
  output logic signed [DW-1:0] x10_r,
  output logic signed [DW-1:0] x11_r,
  output logic signed [DW-1:0] x12_r,
  output logic signed [DW-1:0] x13_r,
  output logic signed [DW-1:0] x14_r,
  output logic signed [DW-1:0] x15_r,
  output logic signed [DW-1:0] x16_r,
  output logic signed [DW-1:0] x17_r,
  output logic signed [DW-1:0] x18_r,
  output logic signed [DW-1:0] x19_r,
  output logic signed [DW-1:0] x20_r,
  output logic signed [DW-1:0] x21_r,
  output logic signed [DW-1:0] x22_r,
  output logic signed [DW-1:0] x23_r,
  output logic signed [DW-1:0] x24_r,
  output logic signed [DW-1:0] x25_r,
  output logic signed [DW-1:0] x26_r,
  output logic signed [DW-1:0] x27_r,
  output logic signed [DW-1:0] x28_r,
  output logic signed [DW-1:0] x29_r,
  output logic signed [DW-1:0] x30_r,
  output logic signed [DW-1:0] x31_r,
  output logic                 frame_err
);

  localparam int IW = 5;

  logic [DW-1:0] bank_q [2][N];
  logic [DW-1:0] bank_d [2][N];
  logic [1:0]    full_q, full_d;
  logic          wr_bank_q, wr_bank_d;
  logic [IW-1:0] wr_idx_q, wr_idx_d;
  logic          rd_bank_q, rd_bank_d;
  logic          frame_err_q, frame_err_d;

  logic          accept_s;
  logic          release_s;
  logic [IW-1:0] eff_idx_s;
  logic [DW-1:0] x_s [N];

  // Flow control comes only from registered full flags, so in_ready never
  // depends combinationally on out_ready.
  assign in_ready  = ~full_q[wr_bank_q];
  assign out_valid = full_q[rd_bank_q];
  assign frame_err = frame_err_q;

  assign accept_s  = in_valid & in_ready;
  assign release_s = out_valid & out_ready;
  assign eff_idx_s = in_sof ? 5'd0 : wr_idx_q;

  // Next-state: write side fills wr_bank, read side releases rd_bank.
  // A write needs an empty bank and a release needs a full one, so the two
  // never touch the same bank in one cycle.
  always_comb begin
    bank_d      = bank_q;
    full_d      = full_q;
    wr_bank_d   = wr_bank_q;
    wr_idx_d    = wr_idx_q;
    rd_bank_d   = rd_bank_q;
    frame_err_d = accept_s & in_sof & (wr_idx_q != 5'd0);

    if (accept_s) begin
      bank_d[wr_bank_q][eff_idx_s] = in_data;
      if (eff_idx_s == 5'd31) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
        wr_idx_d          = 5'd0;
      end else begin
        wr_idx_d = eff_idx_s + 5'd1;
      end
    end else begin
      wr_idx_d = wr_idx_q;
    end

    if (release_s) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end else begin
      rd_bank_d = rd_bank_q;
    end
  end

  // Parallel frame view, forced to zero while no frame is presented.
  always_comb begin
    for (int k = 0; k < N; k++) begin
      if (out_valid) begin
        x_s[k] = bank_q[rd_bank_q][k];
      end else begin
        x_s[k] = {DW{1'b0}};
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int k = 0; k < N; k++) begin
          bank_q[b][k] <= {DW{1'b0}};
        end
      end
      full_q      <= 2'b00;
      wr_bank_q   <= 1'b0;
      wr_idx_q    <= 5'd0;
      rd_bank_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      bank_q      <= bank_d;
      full_q      <= full_d;
      wr_bank_q   <= wr_bank_d;
      wr_idx_q    <= wr_idx_d;
      rd_bank_q   <= rd_bank_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign x0_r  = x_s[0];
  assign x1_r  = x_s[1];
  assign x2_r  = x_s[2];
  assign x3_r  = x_s[3];
  assign x4_r  = x_s[4];
  assign x5_r  = x_s[5];
  assign x6_r  = x_s[6];
  assign x7_r  = x_s[7];
  assign x8_r  = x_s[8];
  assign x9_r  = x_s[9];
  assign x10_r = x_s[10];
  assign x11_r = x_s[11];
  assign x12_r = x_s[12];
  assign x13_r = x_s[13];
  assign x14_r = x_s[14];
  assign x15_r = x_s[15];
  assign x16_r = x_s[16];
  assign x17_r = x_s[17];
  assign x18_r = x_s[18];
  assign x19_r = x_s[19];
  assign x20_r = x_s[20];
  assign x21_r = x_s[21];
  assign x22_r = x_s[22];
  assign x23_r = x_s[23];
  assign x24_r = x_s[24];
  assign x25_r = x_s[25];
  assign x26_r = x_s[26];
  assign x27_r = x_s[27];
  assign x28_r = x_s[28];
  assign x29_r = x_s[29];
  assign x30_r = x_s[30];
  assign x31_r = x_s[31];

endmodule

// File: tb/tb_fft32_input_buffer.sv
// Self-checking bench for fft32_input_buffer: scenario tasks plus a queue-based
// frame model (pending frames, partial frame) used as the reference.
module tb_fft32_input_buffer;

  typedef logic signed [7:0] frame_t [32];

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic signed [7:0] in_data = 8'sd0;
  logic              in_sof = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic              frame_err;
  logic signed [7:0] x_arr [32];

  int total = 0;
  int bad = 0;

  frame_t            exp_q[$];
  logic signed [7:0] part_q[$];
  logic              exp_err = 1'b0;

  always #5 clk = ~clk;

  fft32_input_buffer #(.DW(8), .N(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sof(in_sof), .out_valid(out_valid), .out_ready(out_ready),
    .x0_r(x_arr[0]),   .x1_r(x_arr[1]),   .x2_r(x_arr[2]),   .x3_r(x_arr[3]),
    .x4_r(x_arr[4]),   .x5_r(x_arr[5]),   .x6_r(x_arr[6]),   .x7_r(x_arr[7]),
    .x8_r(x_arr[8]),   .x9_r(x_arr[9]),   .x10_r(x_arr[10]), .x11_r(x_arr[11]),
    .x12_r(x_arr[12]), .x13_r(x_arr[13]), .x14_r(x_arr[14]), .x15_r(x_arr[15]),
    .x16_r(x_arr[16]), .x17_r(x_arr[17]), .x18_r(x_arr[18]), .x19_r(x_arr[19]),
    .x20_r(x_arr[20]), .x21_r(x_arr[21]), .x22_r(x_arr[22]), .x23_r(x_arr[23]),
    .x24_r(x_arr[24]), .x25_r(x_arr[25]), .x26_r(x_arr[26]), .x27_r(x_arr[27]),
    .x28_r(x_arr[28]), .x29_r(x_arr[29]), .x30_r(x_arr[30]), .x31_r(x_arr[31]),
    .frame_err(frame_err)
  );

  function automatic logic exp_valid();
    return exp_q.size() != 0;
  endfunction

  function automatic logic signed [7:0] exp_x(int k);
    if (exp_q.size() == 0) return 8'sd0;
    return exp_q[0][k];
  endfunction

  // One rising edge; the model advances on the inputs driven before it.
  task automatic tick(output logic acc, output logic hs);
    frame_t f;
    acc = in_valid && (exp_q.size() < 2);
    hs  = out_ready && (exp_q.size() != 0);
    @(posedge clk);
    if (!rst_n) begin
      exp_q.delete();
      part_q.delete();
      exp_err = 1'b0;
      acc = 1'b0;
      hs = 1'b0;
    end else begin
      exp_err = acc && in_sof && (part_q.size() != 0);
      if (hs) void'(exp_q.pop_front());
      if (acc) begin
        if (in_sof) part_q.delete();
        part_q.push_back(in_data);
        if (part_q.size() == 32) begin
          for (int k = 0; k < 32; k++) f[k] = part_q[k];
          exp_q.push_back(f);
          part_q.delete();
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic drain();
    logic a, h;
    in_valid = 1'b0;
    in_sof = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick(a, h);
  endtask

  task automatic test_reset();
    logic a, h;
    int nz;
    rst_n = 1'b0;
    tick(a, h);
    tick(a, h);
    rst_n = 1'b1;
    nz = 0;
    for (int k = 0; k < 32; k++) if (x_arr[k] !== 8'sd0) nz++;
    total += 4;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err got=%b want=0", frame_err); end
    if (nz != 0) begin bad++; $display("FAIL reset_x nonzero_count=%0d want=0", nz); end
  endtask

  task automatic test_single_frame();
    logic a, h;
    out_ready = 1'b1;
    for (int k = 0; k < 32; k++) begin
      in_valid = 1'b1;
      in_data = 8'(k);
      in_sof = (k == 0);
      tick(a, h);
      total += 2;
      if (frame_err !== 1'b0) begin bad++; $display("FAIL single_err k=%0d got=%b want=0", k, frame_err); end
      if (out_valid !== (k == 31)) begin bad++; $display("FAIL single_valid k=%0d got=%b want=%b", k, out_valid, k == 31); end
    end
    for (int k = 0; k < 32; k++) begin
      total++;
      if (x_arr[k] !== 8'(k)) begin bad++; $display("FAIL single_x k=%0d got=%0d want=%0d", k, x_arr[k], k); end
    end
    in_valid = 1'b0;
    in_sof = 1'b0;
    tick(a, h);
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL single_one_cycle got=%b want=0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic a, h;
    int s, fr, cyc, hs_cyc;
    drain();
    out_ready = 1'b0;
    s = 0; fr = 0; cyc = 0; hs_cyc = -10;
    while (fr < 3 && cyc < 400) begin
      in_valid = (s < 96);
      in_data = 8'(s);
      in_sof = (s % 32 == 0);
      out_ready = (cyc >= 80);
      if (out_valid === 1'b1 && out_ready) begin
        for (int k = 0; k < 32; k++) begin
          total++;
          if (x_arr[k] !== 8'(32 * fr + k)) begin
            bad++; $display("FAIL b2b_x frame=%0d k=%0d got=%0d want=%0d", fr, k, x_arr[k], 32 * fr + k);
          end
        end
        if (fr == 0) hs_cyc = cyc;
        fr++;
      end
      tick(a, h);
      if (a) s++;
      total++;
      if (in_ready !== (exp_q.size() < 2)) begin
        bad++; $display("FAIL b2b_in_ready cyc=%0d got=%b want=%b", cyc, in_ready, exp_q.size() < 2);
      end
      if (a && s == 64) begin
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_stall after 64 got=%b want=0", in_ready); end
      end
      if (cyc == hs_cyc) begin
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_resume got=%b want=1", in_ready); end
      end
      cyc++;
    end
    total++;
    if (fr != 3 || s != 96) begin bad++; $display("FAIL b2b_timeout frames=%0d want=3 samples=%0d want=96", fr, s); end
  endtask

  task automatic test_sof_error();
    logic a, h;
    int errs;
    drain();
    errs = 0;
    for (int k = 0; k < 42; k++) begin
      in_valid = 1'b1;
      in_sof = (k == 10);
      if (k < 10) in_data = 8'(100 + k);
      else if (k == 10) in_data = -8'sd5;
      else in_data = 8'(20 + k - 10);
      tick(a, h);
      if (frame_err === 1'b1) errs++;
      if (k == 10) begin
        total++;
        if (frame_err !== 1'b1) begin bad++; $display("FAIL sof_err_pulse got=%b want=1", frame_err); end
      end
    end
    in_valid = 1'b0;
    in_sof = 1'b0;
    total += 2;
    if (errs != 1) begin bad++; $display("FAIL sof_err_count got=%0d want=1", errs); end
    if (out_valid !== 1'b1) begin bad++; $display("FAIL sof_valid got=%b want=1", out_valid); end
    for (int k = 0; k < 32; k++) begin
      total++;
      if (x_arr[k] !== ((k == 0) ? -8'sd5 : 8'(20 + k))) begin
        bad++; $display("FAIL sof_x k=%0d got=%0d want=%0d", k, x_arr[k], (k == 0) ? -5 : 20 + k);
      end
    end
  endtask

  task automatic test_hold();
    logic a, h;
    logic signed [7:0] d [32];
    int diff;
    drain();
    out_ready = 1'b0;
    for (int k = 0; k < 32; k++) begin
      d[k] = 8'($urandom);
      in_valid = 1'b1;
      in_data = d[k];
      in_sof = (k == 0);
      tick(a, h);
    end
    in_valid = 1'b0;
    in_sof = 1'b0;
    for (int c = 0; c < 50; c++) begin
      diff = 0;
      for (int k = 0; k < 32; k++) if (x_arr[k] !== d[k]) diff++;
      total += 2;
      if (out_valid !== 1'b1) begin bad++; $display("FAIL hold_valid cyc=%0d got=%b want=1", c, out_valid); end
      if (diff != 0) begin bad++; $display("FAIL hold_x cyc=%0d differing=%0d want=0", c, diff); end
      tick(a, h);
    end
    out_ready = 1'b1;
    tick(a, h);
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL hold_release got=%b want=0", out_valid); end
  endtask

  task automatic test_reset_mid();
    logic a, h;
    logic signed [7:0] d [32];
    int nz;
    drain();
    for (int k = 0; k < 20; k++) begin
      in_valid = 1'b1;
      in_data = 8'($urandom);
      in_sof = (k == 0);
      tick(a, h);
    end
    in_valid = 1'b0;
    in_sof = 1'b0;
    rst_n = 1'b0;
    tick(a, h);
    rst_n = 1'b1;
    for (int k = 0; k < 32; k++) begin
      nz = 0;
      for (int j = 0; j < 32; j++) if (x_arr[j] !== 8'sd0) nz++;
      total += 2;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid k=%0d got=%b want=0", k, out_valid); end
      if (nz != 0) begin bad++; $display("FAIL rstmid_zero k=%0d nonzero=%0d want=0", k, nz); end
      d[k] = 8'($urandom);
      in_valid = 1'b1;
      in_data = d[k];
      in_sof = (k == 0);
      tick(a, h);
    end
    in_valid = 1'b0;
    in_sof = 1'b0;
    total++;
    if (out_valid !== 1'b1) begin bad++; $display("FAIL rstmid_frame_valid got=%b want=1", out_valid); end
    for (int k = 0; k < 32; k++) begin
      total++;
      if (x_arr[k] !== d[k]) begin bad++; $display("FAIL rstmid_x k=%0d got=%0d want=%0d", k, x_arr[k], d[k]); end
    end
  endtask

  task automatic test_alternating();
    logic a, h;
    int k, cyc;
    drain();
    out_ready = 1'b0;
    k = 0; cyc = 0;
    while (k < 32 && cyc < 500) begin
      in_valid = 1'($urandom);
      in_data = (k % 2 == 0) ? 8'sh80 : 8'sh7f;
      in_sof = (k == 0);
      tick(a, h);
      if (a) k++;
      cyc++;
    end
    in_valid = 1'b0;
    in_sof = 1'b0;
    total++;
    if (k != 32 || out_valid !== 1'b1) begin bad++; $display("FAIL alt_timeout accepted=%0d want=32 valid=%b", k, out_valid); end
    for (int j = 0; j < 32; j++) begin
      total++;
      if (x_arr[j] !== ((j % 2 == 0) ? -8'sd128 : 8'sd127)) begin
        bad++; $display("FAIL alt_x k=%0d got=%0d want=%0d", j, x_arr[j], (j % 2 == 0) ? -128 : 127);
      end
    end
    out_ready = 1'b1;
    tick(a, h);
  endtask

  task automatic test_random_stream();
    logic a, h;
    int diff;
    drain();
    for (int c = 0; c < 1500; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_data = 8'($urandom);
      in_sof = ($urandom_range(0, 39) == 0);
      out_ready = ($urandom_range(0, 2) == 0);
      tick(a, h);
      diff = 0;
      for (int k = 0; k < 32; k++) if (x_arr[k] !== exp_x(k)) diff++;
      total += 4;
      if (in_ready !== (exp_q.size() < 2)) begin bad++; $display("FAIL rnd_in_ready cyc=%0d got=%b want=%b", c, in_ready, exp_q.size() < 2); end
      if (out_valid !== exp_valid()) begin bad++; $display("FAIL rnd_out_valid cyc=%0d got=%b want=%b", c, out_valid, exp_valid()); end
      if (frame_err !== exp_err) begin bad++; $display("FAIL rnd_frame_err cyc=%0d got=%b want=%b", c, frame_err, exp_err); end
      if (diff != 0) begin bad++; $display("FAIL rnd_x cyc=%0d differing=%0d want=0", c, diff); end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_sof_error();
    test_hold();
    test_reset_mid();
    test_alternating();
    test_random_stream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fft32_input_buffer.md
# fft32_input_buffer

Serial-to-parallel ping-pong frame buffer feeding the 32-point FFT datapath. It accepts one signed real sample per cycle over a valid/ready stream and assembles frames of 32 samples. It presents each complete frame in parallel as x0_r..x31_r to the first butterfly stage, which pairs x[n] with x[n+16]. Two banks allow gap-free streaming: one bank fills while the other is held for the downstream stage.

## Interface

- DW, 8, sample width (signed two's complement)
- N, 32, samples per frame (fixed at 32; index width 5)

- clk  input  1  rising-edge clock, single clock domain
- rst_n  input  1  reset, synchronous, active-low
- in_valid  input  1  input sample valid
- in_ready  output  1  buffer can accept a sample
- in_data  input  DW  signed input sample
- in_sof  input  1  start-of-frame; qualifies in_data as sample index 0
- out_valid  output  1  complete frame presented on x0_r..x31_r
- out_ready  input  1  downstream consumes the frame
- x0_r..x31_r  output  DW each  signed frame samples, index k on xk_r
- frame_err  output  1  one-cycle pulse: in_sof received mid-frame

## Operation

- Storage: two banks B0/B1, each with 32 × DW registers and a full flag.
- Write side: pointers wr_bank (1 b) and wr_idx (5 b).
  - in_ready = !full[wr_bank].
  - Accept is in_valid && in_ready.
  - On accept, the effective index is 0 if in_sof, else wr_idx. bank[wr_bank][eff] <= in_data.
  - If eff == 31: set full[wr_bank], toggle wr_bank, wr_idx <= 0. Otherwise wr_idx <= eff + 1.
- in_sof handling:
  - in_sof on accept with wr_idx != 0 discards the partial frame, restarts at index 0, and pulses frame_err for 1 cycle.
  - in_sof with wr_idx == 0 is normal, with no error.
  - in_sof without accept is ignored.
  - in_sof is not required. A headerless stream frames on every 32 accepted samples.
- Read side: pointer rd_bank (1 b).
  - out_valid = full[rd_bank].
  - xk_r = bank[rd_bank][k] when out_valid, else 0.
  - On out_valid && out_ready: clear full[rd_bank] and toggle rd_bank.
- Frames are delivered strictly in fill order and are never dropped or overwritten.
- Data passes through unmodified: no scaling, rounding or sign change.
- Simultaneous events:
  - A write completing one bank and a read releasing the other bank in the same cycle are independent. Both take effect.
  - A write can never target a full bank, because in_ready gates it.

## Timing

- Reset (rst_n low at a rising edge) sets:
  - full[0] and full[1] = 0, wr_bank = rd_bank = 0, wr_idx = 0.
  - All bank registers = 0.
  - Outputs: in_ready = 1, out_valid = 0, x0_r..x31_r = 0, frame_err = 0.
- Reset mid-frame discards all partial and complete frames. No out_valid follows from pre-reset data.
- Latency: if the 32nd sample is accepted at edge t, out_valid is high in the cycle following t.
- While out_valid && !out_ready, x0_r..x31_r and out_valid hold stable.
- in_ready derives only from registered full flags and has no combinational path from out_ready.
  - With both banks full, in_ready rises in the cycle after the out_ready handshake.
- Throughput: 1 sample/cycle sustained when out_ready is high at least once per 32 cycles.
- frame_err is high in the cycle following the offending accept.

## Test plan

- Reset, then stream in_data = k for k = 0..31 (sof on k=0), out_ready = 1 → out_valid high one cycle after the 32nd accept, xk_r = k, out_valid for exactly 1 cycle, frame_err never set.
- out_ready = 0, stream 3 frames back-to-back (frame f, sample k = 32f + k, mod-256 signed) → in_ready falls after 64 accepts. Raise out_ready → frame 0 then frame 1 presented in order, in_ready rises the cycle after the first handshake, and the third frame completes correctly.
- Send 10 samples, then in_sof with data −5 followed by 31 samples → frame_err pulses once, delivered x0_r = −5, earlier 10 samples absent.
- Present a frame with out_ready held low for 50 cycles → x0_r..x31_r and out_valid unchanged every cycle. On the handshake, out_valid drops next cycle (no second frame pending).
- Deassert rst_n for 1 cycle after 20 samples of a frame → no out_valid. The next 32 samples form a correct frame starting at index 0, and all outputs read 0 before it completes.
- Frame of alternating −128/127 with in_valid toggling randomly → xk_r exact (−128 on even k, 127 on odd k), no sign corruption.
